// File: rtl/nes_pad_reader.sv
// NES gamepad (CD4021) reader: drives latch/clock, samples active-low serial data into A..Right byte.
// Optional `NES_PAD_DEBOUNCE_EN: accept a new byte only when two consecutive reads agree.
module nes_pad_reader #(
  parameter int TICK_DIV = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       pad_data_i,
  output logic       pad_latch_o,
  output logic       pad_clk_o,
  output logic [7:0] buttons_o,
  output logic       valid_o,
  output logic       busy_o
);

  localparam int TW = $clog2(2 * TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SAMPLE, S_CLK_HI, S_CLK_LO, S_DONE
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    cap_q;
  logic [7:0]    buttons_q;
  logic          latch_q;
  logic          pclk_q;
  logic          valid_q;
  logic          busy_q;
  logic [1:0]    sync_q;
  logic          poll_strobe;
  logic          pressed;
  logic [7:0]    cap_d;
  logic [7:0]    buttons_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], pad_data_i};
  end

  assign pressed = ~sync_q[1];
  assign cap_d   = {cap_q[6:0], pressed};

  generate
    if (POLL_DIV > 0) begin : g_poll
      localparam int PW = $clog2(POLL_DIV + 1);
      localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
      logic [PW-1:0] poll_cnt_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                poll_cnt_q <= '0;
        else if (poll_cnt_q == POLL_LAST) poll_cnt_q <= '0;
        else                           poll_cnt_q <= poll_cnt_q + PW'(1);
      end

      assign poll_strobe = (poll_cnt_q == POLL_LAST);
    end else begin : g_no_poll
      assign poll_strobe = 1'b0;
    end
  endgenerate

`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0] prev_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      prev_q <= 8'h00;
    else if (state_q == S_SAMPLE && bit_cnt_q == 3'd7)
      prev_q <= cap_d;
  end

  assign buttons_d = (cap_d == prev_q) ? cap_d : buttons_q;
`else
  assign buttons_d = cap_d;
`endif

  // Outputs are set on the transition into each state so they are valid for the whole state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= 3'd0;
      cap_q     <= 8'h00;
      buttons_q <= 8'h00;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i || poll_strobe) begin
            state_q   <= S_LATCH;
            tick_q    <= '0;
            bit_cnt_q <= 3'd0;
            latch_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_LATCH: begin
          if (tick_q == LATCH_LAST) begin
            state_q <= S_SAMPLE;
            tick_q  <= '0;
            latch_q <= 1'b0;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_SAMPLE: begin
          cap_q     <= cap_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          tick_q    <= '0;
          if (bit_cnt_q == 3'd7) begin
            state_q   <= S_DONE;
            valid_q   <= 1'b1;
            buttons_q <= buttons_d;
          end else begin
            state_q <= S_CLK_HI;
            pclk_q  <= 1'b1;
          end
        end
        S_CLK_HI: begin
          if (tick_q == TICK_LAST) begin
            state_q <= S_CLK_LO;
            tick_q  <= '0;
            pclk_q  <= 1'b0;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_CLK_LO: begin
          if (tick_q == TICK_LAST) begin
            state_q <= S_SAMPLE;
            tick_q  <= '0;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          latch_q <= 1'b0;
          pclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch_o = latch_q;
  assign pad_clk_o   = pclk_q;
  assign buttons_o   = buttons_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Console-side reader for a physical NES gamepad (CD4021 parallel-in/serial-out shift register). It drives the pad's latch and clock lines and samples its active-low serial data. It assembles the eight buttons into one byte in the team's standard controller bit order: A=7, B=6, Select=5, Start=4, Up=3, Down=2, Left=1, Right=0. It sits between the board's gamepad pins and the controller port register logic, providing the button byte that is later shifted out to the CPU at $4016/$4017.

## Interface
- TICK_DIV, 300: clk cycles per protocol tick (6 µs at 50 MHz); must be ≥ 4.
- POLL_DIV, 833333: clk cycles between automatic reads (60 Hz at 50 MHz); 0 disables auto-poll; nonzero must be > 16*TICK_DIV+10.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request one read; sampled only in IDLE.
- pad_data  in  1  serial data from pad; active-low (0 = pressed); asynchronous.
- pad_latch  out  1  parallel-load strobe to pad, active-high.
- pad_clk  out  1  shift clock to pad; pad advances on rising edge.
- buttons  out  8  last accepted button byte, active-high, standard bit order.
- valid  out  1  one-cycle pulse at read completion.
- busy  out  1  high in every state except IDLE.

## Operation
- pad_data passes through a 2-flop synchronizer; all sampling uses the synchronized value, inverted (pressed = 1).
- Tick counter: 0..TICK_DIV-1, cleared on every state entry.
- FSM states:
  - IDLE: on start or a poll strobe, go to LATCH.
  - LATCH: pad_latch=1 for 2*TICK_DIV cycles, then go to SAMPLE.
  - SAMPLE: 1 cycle. Shift the inverted bit into the capture register MSB-first and increment the bit count. At count 7 go to DONE; otherwise go to CLK_HI.
  - CLK_HI: pad_clk=1 for TICK_DIV cycles, then go to CLK_LO.
  - CLK_LO: pad_clk=0 for TICK_DIV cycles, then go to SAMPLE.
  - DONE: 1 cycle. Assert valid, load buttons (subject to Configuration), then go to IDLE.
- Bit k is captured at the k-th SAMPLE, so the first bit is A → buttons[7] and the eighth is Right → buttons[0].
- Poll counter: free-running 0..POLL_DIV-1. It issues a one-cycle strobe at POLL_DIV-1, then wraps.
- start or a strobe arriving while busy is dropped and not queued. A simultaneous start and strobe in IDLE produce one read.
- Reset, any time including mid-read:
  - FSM returns to IDLE.
  - pad_latch, pad_clk, valid, busy, buttons, capture register, bit count, tick counter and poll counter all go to 0.
  - Outputs change immediately, without waiting for a clk edge.

## Timing
- Cycle 0 = the IDLE cycle in which start is seen; busy goes high at cycle 1.
- pad_latch is high at cycles 1..2T (T = TICK_DIV).
- Sample k (k = 0..7) occurs at cycle 2T+1+k(2T+1).
- pad_clk pulse j (j = 1..7) is high at cycles 2T+2+(j-1)(2T+1) through 3T+1+(j-1)(2T+1).
- DONE is at cycle 16T+9: valid is high and buttons is updated there. busy is low from cycle 16T+10, when a new start may be accepted.
- Every pad_clk edge is separated from any sample by at least T-1 cycles, which covers synchronizer latency.
- pad_latch and pad_clk are registered outputs and never high simultaneously.

## Configuration
- NES_PAD_DEBOUNCE_EN defined:
  - A prev-capture register (reset 0) holds the previous read.
  - In DONE, buttons loads the new capture only if it equals prev-capture; prev-capture always loads the new capture.
  - valid pulses on every completed read regardless.
- Not defined: buttons loads the new capture on every DONE.

## Test plan
- Bench settings: T=4, POLL_DIV=0, behavioural CD4021 pad model (debounce off unless stated).
- Pad holds A+Right, start at cycle 0 → pad_latch high cycles 1..8, seven pad_clk pulses each 4 cycles high, valid at cycle 73 only, buttons=8'h81, busy low at 74.
- No buttons pressed (pad_data=1) → buttons=8'h00; pad_data held 0 → buttons=8'hFF.
- start pulsed again at cycle 10 during a read → exactly one valid (cycle 73); a start at cycle 74 gives valid at cycle 147.
- reset_n low at cycle 30 → pad_latch, pad_clk, busy, buttons immediately 0; after release, start gives a correct read with valid 73 cycles later.
- POLL_DIV=200, start tied 0 → valid pulses exactly 200 cycles apart, buttons tracks the pad pattern (Start pressed → 8'h10).
- Debounce on: reads of 8'h10 then 8'h10 → buttons 8'h00 after first read, 8'h10 after second; a single glitched read of 8'h11 → buttons stays 8'h10.
